// File: rtl/super_i3_bch_outer_source_pkg.sv
// Shared geometry and types for the I.3 outer BCH(3860,3824) source framer.
// 128-bit stream words are split into 8 lanes of 16 bits; a frame spans 242 words.
package super_i3_bch_outer_source_pkg;

    localparam int cDEC_NUM    = 8;
    localparam int cDAT_W      = 16;
    localparam int cFRAME_SIZE = 242;
    localparam int cEOP_EDGE   = 239;
    localparam int cEOF_EDGE   = 242;
    localparam int cADDR_W     = 8;

    typedef logic [cDAT_W-1:0]          dat_t;
    typedef logic [cDEC_NUM*cDAT_W-1:0] ram_dat_t;
    typedef logic [cADDR_W-1:0]         ram_addr_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

endpackage

// File: rtl/super_i3_bch_outer_source_bufctl.sv
// Purpose: ping-pong buffer ownership between the framer and the outer encoders.
// Latency: full/wptr update on the completing word's edge; dat_val two ticks after it.
// Backpressure: rdy drops while the write buffer is still owned by the encoders.
module super_i3_bch_outer_source_bufctl (
    input  logic iclk,
    input  logic ireset,
    input  logic iclkena,
    input  logic frame_done,
    input  logic buf_free,
    output logic wptr,
    output logic rdy,
    output logic dat_val,
    output logic dat_ptr
);

    logic [1:0] full;
    logic [1:0] full_nxt;
    logic       rptr;
    logic       done_d;
    logic       done_ptr;

    assign rdy = ~full[wptr];

    // A completing frame always lands on an empty buffer, so it never collides with a release.
    always_comb begin
        full_nxt = full;
        if (buf_free && full[rptr])
            full_nxt[rptr] = 1'b0;
        if (frame_done)
            full_nxt[wptr] = 1'b1;
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            full     <= 2'b00;
            wptr     <= 1'b0;
            rptr     <= 1'b0;
            done_d   <= 1'b0;
            done_ptr <= 1'b0;
            dat_val  <= 1'b0;
            dat_ptr  <= 1'b0;
        end else if (iclkena) begin
            full     <= full_nxt;
            if (frame_done)
                wptr <= ~wptr;
            if (buf_free && full[rptr])
                rptr <= ~rptr;
            done_d   <= frame_done;
            done_ptr <= wptr;
            dat_val  <= done_d;
            if (done_d)
                dat_ptr <= done_ptr;
        end
    end

endmodule

// File: rtl/super_i3_bch_outer_source.sv
// Purpose: de-interleave stream words into codeword lanes and fill a ping-pong codeword RAM.
// Latency: RAM write one tick after acceptance; odat_val two ticks after the last word.
// Backpressure: ordy low while both buffers await the encoders; frame checker under SUPER_I3_BCH_OUTER_SOURCE_LEN_CHECK_EN.
module super_i3_bch_outer_source
    import super_i3_bch_outer_source_pkg::*;
#(
    parameter int pERR_W = 8
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              iclkena,
    input  logic              ival,
    input  logic              isop,
    input  logic              ieop,
    input  ram_dat_t          idat,
    output logic              ordy,
    output ram_addr_t         owram_addr,
    output logic              owram_ptr,
    output logic              owram_write,
    output dat_t              owram_wdat [cDEC_NUM],
    output logic              odat_val,
    output logic              odat_ptr,
    input  logic              ibuf_free,
    output logic              oerr,
    output logic [pERR_W-1:0] oerr_cnt
);

    state_t    state;
    ram_addr_t cnt;
    ram_addr_t widx;
    logic      wptr;
    logic      acc;
    logic      wr_en;
    logic      frame_done;
    dat_t      lane_dat [cDEC_NUM];

    assign acc        = ival & ordy;
    assign wr_en      = acc & (isop | (state == ST_WRITE));
    assign widx       = isop ? '0 : cnt;
    assign frame_done = acc & ~isop & (state == ST_WRITE) & (cnt == ram_addr_t'(cFRAME_SIZE - 1));

    // The final word of a frame carries lanes contiguously, LSB lane first; all others bit-interleave.
    always_comb begin
        for (int d = 0; d < cDEC_NUM; d++)
            lane_dat[d] = '0;
        for (int d = 0; d < cDEC_NUM; d++) begin
            for (int i = 0; i < cDAT_W; i++) begin
                if (widx == ram_addr_t'(cEOF_EDGE - 1))
                    lane_dat[d][i] = idat[d*cDAT_W + i];
                else
                    lane_dat[d][i] = idat[i*cDEC_NUM + d];
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            owram_write <= 1'b0;
            owram_addr  <= '0;
            owram_ptr   <= 1'b0;
            for (int d = 0; d < cDEC_NUM; d++)
                owram_wdat[d] <= '0;
        end else if (iclkena) begin
            owram_write <= wr_en;
            if (wr_en) begin
                owram_addr <= widx;
                owram_ptr  <= wptr;
                owram_wdat <= lane_dat;
            end
            if (acc) begin
                if (isop) begin
                    state <= ST_WRITE;
                    cnt   <= ram_addr_t'(1);
                end else if (state == ST_WRITE) begin
                    if (frame_done) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end
    end

    super_i3_bch_outer_source_bufctl u_bufctl (
        .iclk       (iclk),
        .ireset     (ireset),
        .iclkena    (iclkena),
        .frame_done (frame_done),
        .buf_free   (ibuf_free),
        .wptr       (wptr),
        .rdy        (ordy),
        .dat_val    (odat_val),
        .dat_ptr    (odat_ptr)
    );

`ifdef SUPER_I3_BCH_OUTER_SOURCE_LEN_CHECK_EN
    logic eop_slot;
    logic len_err;

    assign eop_slot = (widx == ram_addr_t'(cEOP_EDGE - 1));
    assign len_err  = (acc & isop & (state == ST_WRITE)) | (wr_en & (ieop ^ eop_slot));

    always_ff @(posedge iclk) begin
        if (ireset) begin
            oerr     <= 1'b0;
            oerr_cnt <= '0;
        end else if (iclkena) begin
            oerr <= len_err;
            if (len_err && !(&oerr_cnt))
                oerr_cnt <= oerr_cnt + 1'b1;
        end
    end
`else
    // ieop kept referenced so the port stays visibly consumed when the checker is absent.
    assign oerr     = ieop & 1'b0;
    assign oerr_cnt = '0;
`endif

endmodule

// File: tb/tb_super_i3_bch_outer_source.sv
// Bench for super_i3_bch_outer_source: directed lane vectors, frame/buffer corner cases,
// then random traffic compared against a queue-based model of frames and buffer ownership.
module tb_super_i3_bch_outer_source;
    import super_i3_bch_outer_source_pkg::*;

    typedef logic [cDEC_NUM-1:0][cDAT_W-1:0] lanes_t;

    typedef struct {
        bit eof;
        int bitpos;
        int lane;
        int bitn;
    } vec_t;

`ifdef SUPER_I3_BCH_OUTER_SOURCE_LEN_CHECK_EN
    localparam bit LEN_EN = 1'b1;
`else
    localparam bit LEN_EN = 1'b0;
`endif

    logic      iclk = 1'b0;
    logic      ireset, iclkena, ival, isop, ieop, ibuf_free;
    ram_dat_t  idat;
    logic      ordy, owram_ptr, owram_write, odat_val, odat_ptr, oerr;
    ram_addr_t owram_addr;
    dat_t      owram_wdat [cDEC_NUM];
    logic [7:0] oerr_cnt;

    always #5 iclk = ~iclk;

    super_i3_bch_outer_source #(.pERR_W(8)) dut (
        .iclk        (iclk),
        .ireset      (ireset),
        .iclkena     (iclkena),
        .ival        (ival),
        .isop        (isop),
        .ieop        (ieop),
        .idat        (idat),
        .ordy        (ordy),
        .owram_addr  (owram_addr),
        .owram_ptr   (owram_ptr),
        .owram_write (owram_write),
        .owram_wdat  (owram_wdat),
        .odat_val    (odat_val),
        .odat_ptr    (odat_ptr),
        .ibuf_free   (ibuf_free),
        .oerr        (oerr),
        .oerr_cnt    (oerr_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Model: ordered list of buffers held by the encoders, next buffer to fill, frame position.
    int filled[$];
    int wbuf;
    int pos;
    bit d1;
    int d1ptr;
    int err_cnt_m;
    int obs_val;
    int last_stalls;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic lanes_t ref_lanes(input ram_dat_t w, input bit eof);
        lanes_t l;
        l = '0;
        for (int b = 0; b < cDEC_NUM*cDAT_W; b++) begin
            if (eof) l[b / cDAT_W][b % cDAT_W] = w[b];
            else     l[b % cDEC_NUM][b / cDEC_NUM] = w[b];
        end
        return l;
    endfunction

    function automatic lanes_t dut_lanes();
        lanes_t l;
        for (int d = 0; d < cDEC_NUM; d++) l[d] = owram_wdat[d];
        return l;
    endfunction

    function automatic ram_dat_t rnd_word();
        ram_dat_t r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r;
    endfunction

    // One clock: drive at negedge, predict, let the edge pass, compare at the next negedge.
    task automatic cyc(input bit v, input bit s, input bit e, input ram_dat_t d, input bit f,
                       output bit acc);
        bit rdy_m, wr, done, err;
        int idx, exp_ptr;
        lanes_t exp_l;
        ival = v; isop = s; ieop = e; idat = d; ibuf_free = f;
        rdy_m = (filled.size() < 2);
        chk("ordy", ordy, rdy_m);
        acc   = v && rdy_m;
        wr    = acc && (s || pos >= 0);
        idx   = s ? 0 : pos;
        exp_l = ref_lanes(d, idx == cEOF_EDGE-1);
        err   = acc && ((s && pos >= 0) || (wr && (e != (idx == cEOP_EDGE-1))));
        done  = wr && (idx == cFRAME_SIZE-1);
        exp_ptr = wbuf;
        if (wr) pos = done ? -1 : idx + 1;
        if (f && filled.size() > 0) void'(filled.pop_front());
        if (done) begin
            filled.push_back(wbuf);
            wbuf ^= 1;
        end
        if (!LEN_EN) err = 1'b0;
        if (err && err_cnt_m < 255) err_cnt_m++;
        @(posedge iclk);
        @(negedge iclk);
        chk("owram_write", owram_write, wr);
        if (wr) begin
            chk("owram_addr", owram_addr, idx);
            chk("owram_ptr", owram_ptr, exp_ptr);
            chk("owram_wdat", dut_lanes(), exp_l);
        end
        chk("odat_val", odat_val, d1);
        if (d1) chk("odat_ptr", odat_ptr, d1ptr);
        if (odat_val) obs_val++;
        chk("oerr", oerr, err);
        chk("oerr_cnt", oerr_cnt, err_cnt_m);
        d1    = done;
        d1ptr = exp_ptr;
    endtask

    task automatic do_reset();
        ireset = 1'b1; iclkena = 1'b1; ival = 1'b0; isop = 1'b0; ieop = 1'b0;
        ibuf_free = 1'b0; idat = '0;
        repeat (2) @(posedge iclk);
        @(negedge iclk);
        chk("rst_ordy", ordy, 1'b1);
        chk("rst_owram_write", owram_write, 1'b0);
        chk("rst_owram_addr", owram_addr, 0);
        chk("rst_owram_ptr", owram_ptr, 1'b0);
        chk("rst_odat_val", odat_val, 1'b0);
        chk("rst_odat_ptr", odat_ptr, 1'b0);
        chk("rst_oerr", oerr, 1'b0);
        chk("rst_oerr_cnt", oerr_cnt, 0);
        ireset = 1'b0;
        filled.delete();
        wbuf = 0; pos = -1; d1 = 1'b0; d1ptr = 0; err_cnt_m = 0; obs_val = 0;
    endtask

    task automatic idle(input int n, input bit f);
        bit a;
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, '0, f, a);
    endtask

    // Sends words 0..n-1 of a frame, holding each until accepted; optionally releases one buffer on a stall.
    task automatic send_frame(input int n, input int eop_idx, input bit free_on_stall);
        int idx, stalls;
        bit a, fr;
        idx = 0; stalls = 0; fr = 1'b0;
        while (idx < n && stalls < 64) begin
            cyc(1'b1, idx == 0, idx == eop_idx, rnd_word(), fr, a);
            if (a) begin
                idx++;
                fr = 1'b0;
            end else begin
                stalls++;
                fr = free_on_stall && (stalls == 1);
            end
        end
        chk("send_progress", idx, n);
        last_stalls = stalls;
    endtask

    initial begin
        vec_t vecs [9];
        ram_dat_t one;
        bit a;
        one = 1;
        vecs[0] = '{1'b0,   1, 1,  0};
        vecs[1] = '{1'b0,   8, 0,  1};
        vecs[2] = '{1'b0,   9, 1,  1};
        vecs[3] = '{1'b0, 127, 7, 15};
        vecs[4] = '{1'b0,  37, 5,  4};
        vecs[5] = '{1'b1,  16, 1,  0};
        vecs[6] = '{1'b1,   0, 0,  0};
        vecs[7] = '{1'b1, 127, 7, 15};
        vecs[8] = '{1'b1,  37, 2,  5};

        @(negedge iclk);
        do_reset();

        // Lane mapping vectors: interleaved words via frame starts, contiguous final word via full frames.
        for (int v = 0; v < 9; v++) begin
            if (!vecs[v].eof) begin
                cyc(1'b1, 1'b1, 1'b0, one << vecs[v].bitpos, 1'b0, a);
                chk("vec_addr0", owram_addr, 0);
            end else begin
                send_frame(cFRAME_SIZE-1, cEOP_EDGE-1, 1'b0);
                cyc(1'b1, 1'b0, 1'b0, one << vecs[v].bitpos, 1'b0, a);
                chk("vec_addr_last", owram_addr, cEOF_EDGE-1);
            end
            chk("vec_lane", owram_wdat[vecs[v].lane], dat_t'(1) << vecs[v].bitn);
            chk("vec_popcount", $countones(dut_lanes()), 1);
            if (vecs[v].eof) idle(1, 1'b1);
        end

        // Clock enable low must freeze everything despite active inputs.
        idle(2, 1'b0);
        iclkena = 1'b0; ival = 1'b1; isop = 1'b1; ibuf_free = 1'b1; idat = rnd_word();
        repeat (3) @(posedge iclk);
        @(negedge iclk);
        chk("frz_owram_write", owram_write, 1'b0);
        chk("frz_odat_val", odat_val, 1'b0);
        chk("frz_ordy", ordy, filled.size() < 2);
        iclkena = 1'b1; ival = 1'b0; isop = 1'b0; ibuf_free = 1'b0;
        idle(1, 1'b0);

        // Three back-to-back frames with no release: third stalls until one buffer frees.
        do_reset();
        send_frame(cFRAME_SIZE, cEOP_EDGE-1, 1'b0);
        send_frame(cFRAME_SIZE, cEOP_EDGE-1, 1'b0);
        send_frame(cFRAME_SIZE, cEOP_EDGE-1, 1'b1);
        chk("f3_stalled", last_stalls > 0, 1'b1);
        idle(3, 1'b0);
        chk("f3_odat_count", obs_val, 3);

        // Restart at word 5.
        do_reset();
        send_frame(5, cEOP_EDGE-1, 1'b0);
        send_frame(cFRAME_SIZE, cEOP_EDGE-1, 1'b0);
        idle(3, 1'b0);
        chk("restart_odat_count", obs_val, 1);
        chk("restart_err_cnt", oerr_cnt, LEN_EN ? 1 : 0);

        // Early ieop at index 10.
        do_reset();
        send_frame(11, 10, 1'b0);
        chk("early_eop_err_cnt", oerr_cnt, LEN_EN ? 1 : 0);

        // Reset mid-frame at word 100, then one clean frame.
        do_reset();
        send_frame(100, cEOP_EDGE-1, 1'b0);
        do_reset();
        send_frame(cFRAME_SIZE, cEOP_EDGE-1, 1'b0);
        idle(3, 1'b0);
        chk("rst_mid_odat_count", obs_val, 1);

        // Random traffic.
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            bit v, s, e, f;
            int nidx;
            v = ($urandom % 4) != 0;
            s = (pos < 0) ? (($urandom % 3) == 0) : (($urandom % 400) == 0);
            nidx = s ? 0 : pos;
            e = (nidx == cEOP_EDGE-1) ^ (($urandom % 300) == 0);
            f = ($urandom % 12) == 0;
            cyc(v, s, e, rnd_word(), f, a);
        end
        idle(3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
